// File: rtl/alu_pkg.sv
// Shared opcode encoding, command bundle and pipeline-occupancy states
// for the ALU command front-end.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_ASR  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_ASL  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ISSUED,
        ST_RESULT,
        ST_FULL
    } occ_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command buffer with wrap-around pointers, occupancy count and
// full/empty flags. Ports: clk, rst_n, push/din, pop/dout, full, empty, count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  alu_cmd_t                   din,
    input  logic                       pop,
    output alu_cmd_t                   dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front-end for the combinational 8-bit ALU: FIFO intake, registered
// issue stage and registered result stage with valid/ready on both sides.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b (intake), alu_a/alu_b/alu_op
// and alu_out (ALU side), res_valid/res_ready/res_data/res_op (result side),
// illegal_cnt (saturating count of accepted opcodes above OP_MAX).
// Build option ALU_ILLEGAL_DROP_EN: illegal commands are counted but dropped.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [3:0]       res_op,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    alu_cmd_t        f_din;
    alu_cmd_t        f_dout;
    logic            f_push;
    logic            f_pop;
    logic            f_full;
    logic            f_empty;
    logic [CW-1:0]   f_count;
    logic            unused_cnt;

    logic            accept;
    logic            illegal;
    logic            issue_valid;
    logic            stage_free;
    logic            capture;
    logic            load;

    occ_t            state;
    occ_t            state_nx;

    // ---------------- intake ----------------
    assign cmd_ready = !f_full;
    assign accept    = cmd_valid && cmd_ready;
    assign illegal   = is_illegal(cmd_op);
    assign f_din     = '{op: cmd_op, a: cmd_a, b: cmd_b};

`ifdef ALU_ILLEGAL_DROP_EN
    assign f_push = accept && !illegal;
`else
    assign f_push = accept;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .din   (f_din),
        .pop   (f_pop),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign unused_cnt = ^f_count;

    // ---------------- issue / result ----------------
    assign issue_valid = (state == ST_ISSUED) || (state == ST_FULL);
    assign res_valid   = (state == ST_RESULT) || (state == ST_FULL);
    assign stage_free  = !res_valid || res_ready;

    // Capture only a live issue slot, so a stale ALU output never lands.
    assign capture = issue_valid && stage_free;
    // Refill the issue slot when it is empty or is being drained this cycle.
    assign load    = !f_empty && (!issue_valid || stage_free);
    assign f_pop   = load;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_EMPTY: begin
                state_nx = load ? ST_ISSUED : ST_EMPTY;
            end
            ST_ISSUED: begin
                // Result slot is free, so the issued command always moves on.
                state_nx = load ? ST_FULL : ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_nx = load ? ST_ISSUED : ST_EMPTY;
                end else begin
                    state_nx = load ? ST_FULL : ST_RESULT;
                end
            end
            ST_FULL: begin
                if (res_ready) begin
                    state_nx = load ? ST_FULL : ST_RESULT;
                end else begin
                    state_nx = ST_FULL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // alu_* hold their last value while the issue slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= OP_IDLE;
        end else if (load) begin
            alu_a  <= f_dout.a;
            alu_b  <= f_dout.b;
            alu_op <= f_dout.op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_op   <= '0;
        end else if (capture) begin
            res_data <= alu_out;
            res_op   <= alu_op;
        end
    end

    // ---------------- illegal opcode counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
